// File: rtl/cordic_pkg.sv
// Shared definitions for blocks that front the iterative CORDIC core.
// Holds core geometry, the arbiter state encoding and a width helper.
package cordic_pkg;

  localparam int CORDIC_W = 16;
  localparam int CORE_LAT = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  // Index width for n items; never below 1 so a 1-bit pointer still exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side bus of the CORDIC arbiter: angle requests in, results out.
interface cordic_arbiter_if
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CORDIC_W
) ();
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][W-1:0] req_z;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [W-1:0]           rsp_x;
  logic [W-1:0]           rsp_y;
  logic                   rsp_err;

  modport master (
    output req, req_z, rsp_ready,
    input  gnt, rsp_valid, rsp_x, rsp_y, rsp_err
  );

  modport slave (
    input  req, req_z, rsp_ready,
    output gnt, rsp_valid, rsp_x, rsp_y, rsp_err
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
// Produces both one-hot and binary forms of the winner.
module rr_picker
  import cordic_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] j;

  // Scan from farthest to nearest so the nearest candidate after 'last' is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NREQ);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Time-shares one iterative CORDIC core between NREQ requesters, round-robin,
// with a watchdog that turns a hung core into an error response.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = CORDIC_W,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  cordic_arbiter_if.slave rq,
  output logic         core_en,
  output logic [W-1:0] core_z,
  input  logic         core_done,
  input  logic [W-1:0] core_x,
  input  logic [W-1:0] core_y,
  output logic         busy,
  output logic         timeout_err
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(TIMEOUT);

  state_t          state;
  logic [IW-1:0]   idx, last, pick_idx;
  logic [NREQ-1:0] sel, pick_oh;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] gnt, rsp_valid;
  logic [W-1:0]    rsp_x, rsp_y;
  logic            rsp_err;

  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (rq.req),
    .last (last),
    .gnt  (pick_oh),
    .idx  (pick_idx)
  );

  assign rq.gnt       = gnt;
  assign rq.rsp_valid = rsp_valid;
  assign rq.rsp_x     = rsp_x;
  assign rq.rsp_y     = rsp_y;
  assign rq.rsp_err   = rsp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      sel         <= '0;
      last        <= IW'(NREQ - 1);
      cnt         <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_x       <= '0;
      rsp_y       <= '0;
      rsp_err     <= 1'b0;
      core_en     <= 1'b0;
      core_z      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt     <= '0;
      core_en <= 1'b0;
      case (state)
        IDLE: if (|rq.req) begin
          // The angle goes straight into core_z so it is valid during the launch cycle.
          idx     <= pick_idx;
          sel     <= pick_oh;
          core_z  <= rq.req_z[pick_idx];
          gnt     <= pick_oh;
          core_en <= 1'b1;
          busy    <= 1'b1;
          state   <= LAUNCH;
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_x     <= core_x;
            rsp_y     <= core_y;
            rsp_err   <= 1'b0;
            rsp_valid <= sel;
            state     <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_x       <= '0;
            rsp_y       <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
            rsp_valid   <= sel;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (rq.rsp_ready[idx]) begin
          last      <= idx;
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Shares one iterative 16-bit CORDIC rotation core between NREQ independent requesters, such as tone generators or mixers.
- Accepts angle requests and picks one per transaction, round-robin.
- Launches the core with a single-cycle enable, waits for its done pulse and captures the result.
- Returns the result to the winning requester over a valid/ready handshake.
- A watchdog recovers from a core that never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, angle/result width; must match the core
TIMEOUT, 64, max cycles in WAIT before abort (must exceed core latency of 16)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request; held until gnt seen
req_z  in  NREQ*W  packed angles; slice i belongs to requester i
gnt  out  NREQ  one-hot, 1-cycle pulse: request accepted, req_z sampled
rsp_valid  out  NREQ  one-hot; result ready for requester i
rsp_ready  in  NREQ  per-requester result accept
rsp_x  out  W  cosine result (shared bus, meaningful only with rsp_valid)
rsp_y  out  W  sine result
rsp_err  out  1  qualifies rsp_valid: result is a timeout abort (x=y=0)
core_en  out  1  1-cycle launch pulse to core
core_z  out  W  angle to core; stable while core_en=1
core_done  in  1  core completion pulse; core_x/core_y valid only this cycle
core_x  in  W  core cosine output
core_y  in  W  core sine output
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky; set on any watchdog abort, cleared only by rst

Behaviour:
- Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_x=rsp_y=0, rsp_err=0, core_en=0, core_z=0, busy=0, timeout_err=0.
- Reset values (internal): rr pointer last=NREQ-1, so requester 0 has top priority first.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if |req, pick the winner i.
  - Winner is the first set bit scanning last+1, last+2, … (mod NREQ).
  - Latch idx=i and zl=req_z[i].
  - Go to LAUNCH. If no req, stay in IDLE.
- LAUNCH (1 cycle): gnt[idx]=1, core_en=1, core_z=zl. Clear the watchdog counter. Go to WAIT.
- core_z holds zl from LAUNCH through WAIT.
- WAIT, on core_done: latch rsp_x=core_x, rsp_y=core_y, rsp_err=0. Go to RESP.
- WAIT, watchdog: counter increments each cycle. If it reaches TIMEOUT-1 without core_done: rsp_x=rsp_y=0, rsp_err=1, timeout_err=1. Go to RESP.
- WAIT: core_done and timeout in the same cycle → core_done wins.
- RESP: rsp_valid[idx]=1, with data held stable until rsp_ready[idx].
  - On that handshake cycle: last=idx, clear rsp_valid, go to IDLE.
  - rsp_ready of other requesters is ignored.
- Latency with the standard core (done arrives 16 cycles after core_en):
  - req first sampled at cycle t → gnt/core_en at t+1 → core_done at t+17 → rsp_valid from t+18.
  - Back-to-back minimum period is 19 cycles per transaction.
- core_done outside WAIT (spurious, or a late done after a timeout) is ignored; no state change.
- req dropped before being sampled in IDLE: never granted, no side effect.
- req[idx] still high after its gnt: treated as a new request at the next IDLE.
- A new req arriving in RESP together with rsp_ready: no bypass; it is picked in the following IDLE cycle.
- rst mid-WAIT/RESP: everything returns to reset values immediately. No rsp is delivered; the core is not re-launched.
- Angle and result are passed through unmodified (no sign or width conversion).

Decomposition:
- Shared package cordic_pkg:
  - CORDIC_W=16, CORE_LAT=16
  - state enum {IDLE, LAUNCH, WAIT, RESP}
  - function clog2 for the idx/pointer width
- Sub-module rr_picker (NREQ):
  - combinational
  - inputs: req vector, last pointer
  - outputs: one-hot grant and binary index
  - reused by other shared-resource blocks.

Test Plan:
(Bench uses a core model that returns x=z, y=~z, 16 cycles after core_en.)
- Single request: req[0]=1, z=16'h2000 → gnt[0] at t+1, core_z=16'h2000, rsp_valid[0] at t+18, rsp_x=16'h2000, rsp_y=16'hDFFF, rsp_err=0.
- Two simultaneous requests: req[2] and req[1] both high from reset → service order 1 then 2, each gnt exactly 1 cycle, second gnt 19 cycles after the first when rsp_ready is tied high.
- Fairness: all 4 reqs held high for 8 transactions → grant order 0,1,2,3,0,1,2,3; no requester serviced twice before the others.
- Backpressure: rsp_ready[0]=0 for 10 cycles after rsp_valid → rsp_valid/rsp_x/rsp_y stable, busy=1, no core_en. Ready high → IDLE next cycle.
- Timeout: core model never pulses done → after TIMEOUT cycles in WAIT, rsp_valid with rsp_err=1, x=y=0, timeout_err=1 sticky. A late core_done 5 cycles later is ignored.
- Reset mid-WAIT: assert rst 5 cycles after core_en → all outputs 0 asynchronously. After release, req[3] alone is serviced normally and req[0] gets priority over req[1] on a tie.
